// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
// Shared constants and types for the IF/ID pipeline stage:
//   NOP      - instruction word loaded into IF/ID on a control redirect
//   STALL_W  - width of the load-use stall counter
//   state_t  - hazard FSM state encoding (RUN = 0, HOLD = 1)
//   sat_inc  - saturating increment used by the stall counter
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam int          STALL_W = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// ---------------------------------------------------------------------------
// if_id_stage_if
// Bundles every IF/ID stage signal except clk/reset.
//   From IF       : Instruction_if, NextPC_if
//   From EX/MEM   : Z, J, JR (redirects), MemRead_ex, RegWriteAddr_ex
//   To ID         : Instruction_id, NextPC_id, Rs_id, Rt_id, valid_id
//   To IF / ID-EX : PC_IFWrite, Bubble_id
//   Status        : stall_count, state (FSM state for observation)
//
// Handshake semantics: there is no valid/ready pair on the IF side. IF
// presents a new instruction every cycle; PC_IFWrite acts as the ready
// back to IF. When PC_IFWrite = 0 the IF stage must hold its PC, and the
// same Instruction_if/NextPC_if is re-presented next cycle. valid_id
// qualifies Instruction_id: 0 means it holds a flushed NOP.
// ---------------------------------------------------------------------------
interface if_id_stage_if;
  import if_id_stage_pkg::*;

  logic [31:0]        Instruction_if;
  logic [31:0]        NextPC_if;
  logic               Z;
  logic               J;
  logic               JR;
  logic               MemRead_ex;
  logic [4:0]         RegWriteAddr_ex;

  logic [31:0]        Instruction_id;
  logic [31:0]        NextPC_id;
  logic [4:0]         Rs_id;
  logic [4:0]         Rt_id;
  logic               valid_id;
  logic               PC_IFWrite;
  logic               Bubble_id;
  logic [STALL_W-1:0] stall_count;
  state_t             state;

  modport master (
    output Instruction_if, NextPC_if, Z, J, JR, MemRead_ex, RegWriteAddr_ex,
    input  Instruction_id, NextPC_id, Rs_id, Rt_id, valid_id,
           PC_IFWrite, Bubble_id, stall_count, state
  );

  modport slave (
    input  Instruction_if, NextPC_if, Z, J, JR, MemRead_ex, RegWriteAddr_ex,
    output Instruction_id, NextPC_id, Rs_id, Rt_id, valid_id,
           PC_IFWrite, Bubble_id, stall_count, state
  );

endinterface

// File: rtl/if_id_stage_pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg
// Parameterised pipeline register.
//   clk    - clock, rising edge
//   reset  - synchronous active-low reset (q <= 0)
//   en     - load d
//   clr    - synchronous clear to CLR_VAL, takes priority over en
//   d / q  - data in / registered data out
// ---------------------------------------------------------------------------
module pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register with load-use hazard detection and flush.
//   clk   - clock, rising edge
//   reset - synchronous active-low reset
//   bus   - if_id_stage_if.slave (IF inputs, redirects, EX load info,
//           IF/ID contents, PC_IFWrite, Bubble_id, stall_count, state)
//
// A load in EX whose destination matches Rs/Rt of the valid instruction in
// ID stalls the front end for exactly one cycle (RUN -> HOLD -> RUN). A
// redirect (Z | J | JR) always wins over a hazard and flushes IF/ID to a NOP.
// ---------------------------------------------------------------------------
module if_id_stage
  import if_id_stage_pkg::*;
(
  input logic          clk,
  input logic          reset,
  if_id_stage_if.slave bus
);

  state_t             state_q, state_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               redirect;
  logic               hazard;
  logic               load;
  logic               pc_write;
  logic               bubble;
  logic [31:0]        instr_q;
  logic               valid_q;
  logic [4:0]         rs;
  logic [4:0]         rt;

  assign rs = instr_q[25:21];
  assign rt = instr_q[20:16];

  assign redirect = bus.Z | bus.J | bus.JR;

  // valid_q gates the check so a flushed NOP never causes a stall.
  assign hazard = bus.MemRead_ex
                & (bus.RegWriteAddr_ex != 5'd0)
                & ((bus.RegWriteAddr_ex == rs) | (bus.RegWriteAddr_ex == rt))
                & valid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = RUN;
    load        = 1'b1;
    pc_write    = 1'b1;
    bubble      = 1'b0;
    stall_cnt_d = stall_cnt_q;
    // HOLD always falls back to RUN and loads; the hazard is ignored there
    // because the load has moved past EX by then.
    if (state_q == RUN && !redirect && hazard) begin
      state_d     = HOLD;
      load        = 1'b0;
      pc_write    = 1'b0;
      bubble      = 1'b1;
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    // While reset is asserted the front end must free-run with no bubble.
    if (!reset) begin
      pc_write = 1'b1;
      bubble   = 1'b0;
    end
  end

  pipe_reg #(.W(32), .CLR_VAL(NOP)) u_instr_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .clr   (redirect),
    .d     (bus.Instruction_if),
    .q     (instr_q)
  );

  // On a redirect NextPC_id still tracks NextPC_if, so it is never cleared.
  pipe_reg #(.W(32), .CLR_VAL(32'h0)) u_npc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .clr   (1'b0),
    .d     (bus.NextPC_if),
    .q     (bus.NextPC_id)
  );

  pipe_reg #(.W(1), .CLR_VAL(1'b0)) u_valid_reg (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .clr   (redirect),
    .d     (1'b1),
    .q     (valid_q)
  );

  assign bus.Instruction_id = instr_q;
  assign bus.Rs_id          = rs;
  assign bus.Rt_id          = rt;
  assign bus.valid_id       = valid_q;
  assign bus.PC_IFWrite     = pc_write;
  assign bus.Bubble_id      = bubble;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// Directed bench for if_id_stage. Each step drives inputs on the falling
// edge and queues the hand-computed outputs expected in that same cycle
// (registered fields reflect the previous rising edge; PC_IFWrite and
// Bubble_id reflect the freshly driven inputs). A monitor pops and
// compares shortly after every falling edge.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

  localparam int   OBS_W   = 94;
  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic clk;
  logic reset;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset               = 1'b0;
    bus.Instruction_if  = 32'h0;
    bus.NextPC_if       = 32'h0;
    bus.Z               = 1'b0;
    bus.J               = 1'b0;
    bus.JR              = 1'b0;
    bus.MemRead_ex      = 1'b0;
    bus.RegWriteAddr_ex = 5'd0;
  end

  // ---------------- scoreboard ----------------
  logic [OBS_W-1:0] exp_q[$];
  string            name_q[$];
  int               tests_run = 0;
  int               tests_failed = 0;

  // ---------------- driver ----------------
  task automatic step(input logic rst_v, input logic [31:0] ins, input logic [31:0] npc,
                      input logic z, input logic j, input logic jr,
                      input logic mr, input logic [4:0] wa,
                      input logic [31:0] e_ins, input logic [31:0] e_npc,
                      input logic e_valid, input logic e_pcw, input logic e_bub,
                      input logic [15:0] e_cnt, input logic e_state, input string nm);
    logic [OBS_W-1:0] e;
    @(negedge clk);
    reset               = rst_v;
    bus.Instruction_if  = ins;
    bus.NextPC_if       = npc;
    bus.Z               = z;
    bus.J               = j;
    bus.JR              = jr;
    bus.MemRead_ex      = mr;
    bus.RegWriteAddr_ex = wa;
    e = {e_ins, e_npc, e_ins[25:21], e_ins[20:16], e_valid, e_pcw, e_bub, e_cnt, e_state};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [OBS_W-1:0] got;
    logic [OBS_W-1:0] e;
    string            nm;
    #2;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {bus.Instruction_id, bus.NextPC_id, bus.Rs_id, bus.Rt_id, bus.valid_id,
             bus.PC_IFWrite, bus.Bubble_id, bus.stall_count, logic'(bus.state)};
      tests_run++;
      if (got !== e) begin
        tests_failed++;
        $display("FAIL %s: got instr=%h npc=%h rs=%0d rt=%0d v=%b pcw=%b bub=%b cnt=%h st=%b ; exp instr=%h npc=%h rs=%0d rt=%0d v=%b pcw=%b bub=%b cnt=%h st=%b",
                 nm, got[93:62], got[61:30], got[29:25], got[24:20], got[19], got[18], got[17], got[16:1], got[0],
                 e[93:62], e[61:30], e[29:25], e[24:20], e[19], e[18], e[17], e[16:1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // rst ins npc z j jr mr wa | e_ins e_npc v pcw bub cnt st
    step(0, 32'h8C220004, 32'h4,  0,0,0, 0,5'd0, 32'h0, 32'h0, 0,1,0, 16'h0, ST_RUN, "reset_a");
    step(0, 32'h8C220004, 32'h4,  0,1,0, 1,5'd2, 32'h0, 32'h0, 0,1,0, 16'h0, ST_RUN, "reset_b");
    step(1, 32'h8C220004, 32'h4,  0,0,0, 0,5'd0, 32'h0, 32'h0, 0,1,0, 16'h0, ST_RUN, "release");
    step(1, 32'h00432020, 32'h8,  0,0,0, 0,5'd0, 32'h8C220004, 32'h4, 1,1,0, 16'h0, ST_RUN, "first_load");
    step(1, 32'h01095020, 32'hC,  0,0,0, 1,5'd2, 32'h00432020, 32'h8, 1,0,1, 16'h0, ST_RUN, "hazard_rs");
    step(1, 32'h01095020, 32'hC,  0,0,0, 1,5'd2, 32'h00432020, 32'h8, 1,1,0, 16'h1, ST_HOLD, "hold_cycle");
    step(1, 32'h00432020, 32'h10, 0,0,0, 1,5'd0, 32'h01095020, 32'hC, 1,1,0, 16'h1, ST_RUN, "after_stall");
    step(1, 32'h00642820, 32'h14, 0,0,0, 1,5'd0, 32'h00432020, 32'h10, 1,1,0, 16'h1, ST_RUN, "wa_zero");
    step(1, 32'h8C430008, 32'h40, 0,1,0, 1,5'd4, 32'h00642820, 32'h14, 1,1,0, 16'h1, ST_RUN, "redirect_wins");
    step(1, 32'h8C430008, 32'h44, 0,0,0, 0,5'd0, 32'h0, 32'h40, 0,1,0, 16'h1, ST_RUN, "after_jump");
    step(1, 32'h11111111, 32'h48, 1,0,0, 1,5'd3, 32'h8C430008, 32'h44, 1,1,0, 16'h1, ST_RUN, "branch_z");
    step(1, 32'h00432020, 32'h4C, 0,0,0, 0,5'd0, 32'h0, 32'h48, 0,1,0, 16'h1, ST_RUN, "after_z");
    step(1, 32'h8C220004, 32'h50, 0,0,1, 0,5'd0, 32'h00432020, 32'h4C, 1,1,0, 16'h1, ST_RUN, "jr_flush");
    step(1, 32'h00432020, 32'h54, 0,0,0, 0,5'd0, 32'h0, 32'h50, 0,1,0, 16'h1, ST_RUN, "pre_sat");
    // Preload the counter to 16'hFFFE across the next rising edge.
    force dut.stall_cnt_d = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.stall_cnt_d;
    step(1, 32'h01095020, 32'h58, 0,0,0, 1,5'd2, 32'h00432020, 32'h54, 1,0,1, 16'hFFFE, ST_RUN, "sat_stall1");
    step(1, 32'h00432020, 32'h5C, 0,0,0, 1,5'd2, 32'h00432020, 32'h54, 1,1,0, 16'hFFFF, ST_HOLD, "sat_hold1");
    step(1, 32'h00432020, 32'h60, 0,0,0, 1,5'd2, 32'h00432020, 32'h5C, 1,0,1, 16'hFFFF, ST_RUN, "sat_stall2");
    step(1, 32'h00432020, 32'h60, 0,0,0, 1,5'd2, 32'h00432020, 32'h5C, 1,1,0, 16'hFFFF, ST_HOLD, "sat_hold2");
    step(1, 32'h00432020, 32'h64, 0,0,0, 1,5'd2, 32'h00432020, 32'h60, 1,0,1, 16'hFFFF, ST_RUN, "sat_stall3");
    step(0, 32'h00432020, 32'h68, 0,0,0, 1,5'd2, 32'h00432020, 32'h60, 1,1,0, 16'hFFFF, ST_HOLD, "reset_in_hold");
    step(1, 32'h00432020, 32'h6C, 0,0,0, 1,5'd2, 32'h0, 32'h0, 0,1,0, 16'h0, ST_RUN, "post_reset");
    step(1, 32'h00432020, 32'h70, 0,0,0, 0,5'd0, 32'h00432020, 32'h6C, 1,1,0, 16'h0, ST_RUN, "resume");

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have port Instruction_if, input, 32, fetched instruction from IF.
REQ-004 SHALL have port NextPC_if, input, 32, PC+4 from IF.
REQ-005 SHALL have ports Z, J, JR, input, 1 each, redirect indications (branch taken / jump / jump-register) resolved downstream.
REQ-006 SHALL have ports MemRead_ex (input, 1) and RegWriteAddr_ex (input, 5), EX-stage load flag and destination register.
REQ-007 SHALL have ports Instruction_id (output, 32) and NextPC_id (output, 32), registered IF/ID contents.
REQ-008 SHALL have ports Rs_id and Rt_id, output, 5 each, equal to Instruction_id[25:21] and Instruction_id[20:16].
REQ-009 SHALL have port valid_id, output, 1, which is 1 when Instruction_id holds a real, unflushed instruction.
REQ-010 SHALL have port PC_IFWrite, output, 1, PC write enable driven to IF.
REQ-011 SHALL have port Bubble_id, output, 1; when 1, ID/EX SHALL load zeroed control signals.
REQ-012 SHALL have port stall_count, output, 16, saturating count of load-use stall cycles.

Function
REQ-013 SHALL compute redirect = Z | J | JR combinationally.
REQ-014 SHALL compute hazard = MemRead_ex & (RegWriteAddr_ex != 0) & (RegWriteAddr_ex == Rs_id | RegWriteAddr_ex == Rt_id) & valid_id, combinationally.
REQ-015 SHALL implement a 2-state FSM {RUN, HOLD}.
REQ-016 RUN with no redirect and no hazard: IF/ID loads Instruction_if and NextPC_if; valid_id <= 1; PC_IFWrite = 1; Bubble_id = 0; next state RUN.
REQ-017 RUN with hazard and no redirect: IF/ID holds all contents; PC_IFWrite = 0; Bubble_id = 1; stall_count increments; next state HOLD.
REQ-018 HOLD with no redirect: hazard is ignored; IF/ID loads normally; PC_IFWrite = 1; Bubble_id = 0; next state RUN. The stall is therefore exactly one cycle per load-use.
REQ-019 In any state, redirect = 1: Instruction_id <= 32'h00000000 (NOP); NextPC_id <= NextPC_if; valid_id <= 0; PC_IFWrite = 1; Bubble_id = 0; stall_count unchanged; next state RUN.
REQ-020 When redirect and hazard are both 1 in the same cycle, redirect SHALL win.
REQ-021 stall_count SHALL saturate at 16'hFFFF and never wrap to 0.
REQ-022 PC_IFWrite and Bubble_id SHALL be combinational outputs of state, hazard and redirect, with zero latency; IF/ID outputs SHALL have one-cycle latency from the IF inputs.

Reset
REQ-023 While reset = 0 at a rising edge: Instruction_id = 0, NextPC_id = 0, valid_id = 0, stall_count = 0, state = RUN.
REQ-024 While reset = 0: PC_IFWrite = 1 and Bubble_id = 0, regardless of the other inputs.
REQ-025 Reset asserted in HOLD SHALL return the FSM to RUN with no residual stall.

Structure
REQ-026 A shared package SHALL hold the NOP constant (32'h0), the FSM state encoding (RUN = 1'b0, HOLD = 1'b1) and the stall-counter width (16).
REQ-027 One sub-module SHALL be used: pipe_reg, a parameterised-width register with synchronous active-low reset, enable and synchronous clear. It is instantiated for Instruction_id, NextPC_id and valid_id.
REQ-028 The FSM and the saturating counter SHALL reside in if_id_stage.

Verification
REQ-029 Reset held low for 2 cycles, then released, with Instruction_if = 32'h8C220004 and NextPC_if = 32'h00000004 -> first edge after release: Instruction_id = 32'h8C220004, NextPC_id = 4, valid_id = 1.
REQ-030 Instruction_id = 32'h00432020 (rs = 2), MemRead_ex = 1, RegWriteAddr_ex = 2 -> PC_IFWrite = 0 and Bubble_id = 1 for exactly one cycle; Instruction_id held; stall_count = 1.
REQ-031 Same hazard setup as REQ-030 with RegWriteAddr_ex = 0 -> no stall; PC_IFWrite = 1.
REQ-032 J = 1 together with a hazard present -> next edge Instruction_id = 0 and valid_id = 0; PC_IFWrite = 1 in that cycle; stall_count unchanged.
REQ-033 stall_count preloaded to 16'hFFFE, then 3 separate load-use stalls -> stall_count = 16'hFFFF.
REQ-034 Reset = 0 asserted in the HOLD cycle -> next edge state = RUN, all outputs at their reset values.
